spi_cmd_arbiter: RTL and testbench
==================================

Name: spi_cmd_arbiter

Overview:
Shares one spi_master command/response stream pair (16-bit transfers) between NUM_REQ independent requesters, e.g. the adxl345 configuration/data sequencer and a debug or self-test port.
- Round-robin arbitration on the command side.
- Each accepted command records its requester in an in-order tag FIFO, because spi_master returns exactly one response word per command, in order.
- Responses are routed back to the owning requester, or discarded for write-only commands.
- Sits between requester sequencers and spi_master's mosi_stream/miso_stream, in the sys_clk domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 16, command/response word width (matches spi_master TRANSFER_WIDTH)
MAX_OUTSTANDING, 8, tag FIFO depth; maximum commands issued but not yet answered (power of 2, ≥2)

Ports:
sys_clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_tdata  in  NUM_REQ*DATA_WIDTH  command word per requester, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_tuser  in  NUM_REQ  1 = discard response (write-only command)
req_tvalid  in  NUM_REQ  command valid per requester
req_tready  out  NUM_REQ  command accepted per requester
rsp_tdata  out  DATA_WIDTH  response word, shared by all requesters
rsp_tvalid  out  NUM_REQ  response valid, one-hot to owning requester
rsp_tready  in  NUM_REQ  requester ready for response
cmd_tdata  out  DATA_WIDTH  to spi_master mosi_stream
cmd_tvalid  out  1  to spi_master mosi_stream
cmd_tready  in  1  from spi_master mosi_stream
resp_tdata  in  DATA_WIDTH  from spi_master miso_stream
resp_tvalid  in  1  from spi_master miso_stream
resp_tready  out  1  to spi_master miso_stream
outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tag FIFO occupancy
orphan_error  out  1  sticky; a response arrived with no outstanding tag

Behaviour:
- Reset values: cmd_tvalid=0, cmd_tdata=0, req_tready=0, rsp_tvalid=0, resp_tready=0, outstanding=0, orphan_error=0, rr pointer=0, state=ARB_IDLE, tag FIFO empty.
- Reset mid-operation: all state is cleared immediately. Commands already inside spi_master become untracked, and their responses raise orphan_error. Requesters must reset together with spi_master.

Command-side state machine:
- ARB_IDLE:
  - If any req_tvalid and outstanding < MAX_OUTSTANDING, grant the first valid requester at or after the rr pointer (wrap NUM_REQ-1 → 0).
  - Register grant index, tdata and tuser; set cmd_tvalid=1; go to ARB_ISSUE.
  - Latency: command visible on cmd_* one cycle after req_tvalid is sampled.
- ARB_ISSUE:
  - cmd_tvalid/cmd_tdata are held stable until cmd_tready.
  - On handshake:
    - pulse req_tready[grant] for that same cycle (combinational: state==ARB_ISSUE & cmd_tready, one-hot);
    - push tag {grant, discard};
    - cmd_tvalid←0; rr pointer←grant+1 (mod NUM_REQ); return to ARB_IDLE.
  - Throughput: one command per 2 cycles minimum.
- Requesters must hold req_tvalid/tdata stable until req_tready. Deasserting req_tvalid while granted is illegal; the command issues regardless.
- Full: no grant while outstanding == MAX_OUTSTANDING, and req_tready stays 0.

Response side (combinational, zero latency):
- head = tag FIFO head; ne = FIFO not empty.
- rsp_tdata = resp_tdata.
- rsp_tvalid[i] = resp_tvalid & ne & !head.discard & (head.idx==i).
- resp_tready = !ne | head.discard | rsp_tready[head.idx].
- Pop on resp_tvalid & resp_tready & ne.
- Orphan response (resp_tvalid & !ne): accepted and dropped; orphan_error←1 until reset.
- Simultaneous push and pop: occupancy unchanged; both take effect. A pop when full frees a slot for the next ARB_IDLE cycle.
- outstanding = count of pushes minus pops.

Decomposition:
- Package spi_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE};
  - tag_t struct {logic [2:0] idx; logic discard;};
  - MAX_REQ=8.
- Sub-module spi_tag_fifo: synchronous FIFO of tag_t, depth MAX_OUTSTANDING.
  - Ports: push, pop, full, empty, count, head.
  - Same-cycle push+pop is legal when full or empty-with-push.

Test Plan:
1. Single command: req0 tdata=16'h2D08, tuser=1, spi_master model answers 16'h00FF → cmd_tdata=16'h2D08 one cycle after valid, req_tready[0] pulses once, no rsp_tvalid, resp_tready=1, outstanding 0→1→0.
2. Read routing: req1 sends 16'h8000 (tuser=0), response 16'h00E5 → rsp_tvalid=2'b10 with rsp_tdata=16'h00E5. With rsp_tready[1] held 0 for 5 cycles, resp_tready stays 0 and data holds.
3. Round-robin fairness: both requesters continuously valid → issue order 0,1,0,1 (tdata 16'hA000, 16'hB000, ...), and responses return to matching requesters in order.
4. Backpressure/full: MAX_OUTSTANDING=8, spi_master returns nothing → exactly 8 commands issued, outstanding=8, req_tready stays 0. One response → a 9th command issues on the next IDLE cycle.
5. Orphan: resp_tvalid with empty FIFO, data 16'h1234 → accepted, no rsp_tvalid, orphan_error=1 and sticky until reset=0.
6. Async reset asserted in ARB_ISSUE with outstanding=3 → all outputs take their reset values without a clock edge; after release, the first new command issues normally.

Source files
------------

// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared types for the SPI command arbiter: FSM states, response tags and limits.
package spi_arb_pkg;

    // Largest requester count the 3-bit tag index can address.
    localparam int MAX_REQ = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // One tag per issued command: who owns the response and whether to drop it.
    typedef struct packed {
        logic [2:0] idx;
        logic       discard;
    } tag_t;

    // Round-robin successor of a grant index for n requesters.
    function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
        if (int'(g) + 1 >= n) begin
            return 3'd0;
        end
        return g + 3'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// Requester-side and spi_master-side stream bundle of the SPI command arbiter.
interface spi_cmd_arbiter_if #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 8
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    // Requester command streams
    logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata;
    logic [NUM_REQ-1:0]            req_tuser;
    logic [NUM_REQ-1:0]            req_tvalid;
    logic [NUM_REQ-1:0]            req_tready;
    // Requester response streams (shared data, one-hot valid)
    logic [DATA_WIDTH-1:0]         rsp_tdata;
    logic [NUM_REQ-1:0]            rsp_tvalid;
    logic [NUM_REQ-1:0]            rsp_tready;
    // spi_master mosi_stream
    logic [DATA_WIDTH-1:0]         cmd_tdata;
    logic                          cmd_tvalid;
    logic                          cmd_tready;
    // spi_master miso_stream
    logic [DATA_WIDTH-1:0]         resp_tdata;
    logic                          resp_tvalid;
    logic                          resp_tready;
    // Status
    logic [CNT_W-1:0]              outstanding;
    logic                          orphan_error;

    // Arbiter view
    modport slave (
        input  req_tdata, req_tuser, req_tvalid, rsp_tready,
        input  cmd_tready, resp_tdata, resp_tvalid,
        output req_tready, rsp_tdata, rsp_tvalid,
        output cmd_tdata, cmd_tvalid, resp_tready,
        output outstanding, orphan_error
    );

    // Environment view (requesters plus spi_master)
    modport master (
        output req_tdata, req_tuser, req_tvalid, rsp_tready,
        output cmd_tready, resp_tdata, resp_tvalid,
        input  req_tready, rsp_tdata, rsp_tvalid,
        input  cmd_tdata, cmd_tvalid, resp_tready,
        input  outstanding, orphan_error
    );

endinterface

// File: rtl/spi_cmd_arbiter_tag_fifo.sv
// In-order FIFO of response tags; head is readable in the same cycle so the
// response path can route with zero latency.
module spi_tag_fifo
    import spi_arb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  tag_t          push_tag_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output tag_t          head_o
);

    tag_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A pop frees the head slot this cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin sharing of one spi_master command/response stream pair between
// NUM_REQ requesters; responses are routed back using an in-order tag FIFO.
module spi_cmd_arbiter
    import spi_arb_pkg::*;
#(
    parameter  int NUM_REQ         = 2,
    parameter  int DATA_WIDTH      = 16,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic              sys_clk,
    input  logic              reset,
    spi_cmd_arbiter_if.slave  bus
);

    arb_state_t            state_q, state_d;
    logic [2:0]            grant_q, grant_d;
    logic [2:0]            rr_q, rr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  discard_q, discard_d;
    logic                  orphan_q;

    logic                  sel_found;
    logic [2:0]            sel_idx;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    tag_t                  head;
    tag_t                  push_tag;
    logic                  ne;
    logic [NUM_REQ-1:0]    head_sel;
    logic                  owner_ready;

    // Command handshake completes while the registered command is offered.
    assign push     = (state_q == ARB_ISSUE) & bus.cmd_tready;
    assign push_tag = '{idx: grant_q, discard: discard_q};
    assign ne       = ~fifo_empty;

    spi_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i      (sys_clk),
        .rst_ni     (reset),
        .push_i     (push),
        .push_tag_i (push_tag),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .head_o     (head)
    );

    // Pick the first valid requester at or after the round-robin pointer;
    // scanning offsets downward lets the smallest offset win.
    always_comb begin
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = rr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (bus.req_tvalid[j]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(j);
            end
        end
    end

    // Next-state logic: latch a grant in IDLE, wait for the spi_master in ISSUE.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        data_d    = data_q;
        discard_d = discard_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_found && !fifo_full) begin
                    grant_d   = sel_idx;
                    data_d    = bus.req_tdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
                    discard_d = bus.req_tuser[sel_idx];
                    state_d   = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (bus.cmd_tready) begin
                    rr_d    = rr_next(grant_q, NUM_REQ);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Command-side state registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            data_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            data_q    <= data_d;
            discard_q <= discard_d;
        end
    end

    assign bus.cmd_tvalid = (state_q == ARB_ISSUE);
    assign bus.cmd_tdata  = data_q;

    // Per-requester grant acknowledge, head ownership decode and response valid.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign head_sel[gi]       = (head.idx == 3'(gi));
        assign bus.req_tready[gi] = push & (grant_q == 3'(gi));
        assign bus.rsp_tvalid[gi] = bus.resp_tvalid & ne & ~head.discard & head_sel[gi];
    end

    // Write-only and orphan responses are always sunk; otherwise the owner
    // decides. Held low while reset is asserted.
    assign owner_ready     = |(bus.rsp_tready & head_sel);
    assign bus.resp_tready = reset & (~ne | head.discard | owner_ready);
    assign bus.rsp_tdata   = bus.resp_tdata;
    assign pop             = bus.resp_tvalid & bus.resp_tready & ne;

    // Sticky flag for a response that arrived with no command outstanding.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            orphan_q <= 1'b0;
        end else if (bus.resp_tvalid && bus.resp_tready && !ne) begin
            orphan_q <= 1'b1;
        end
    end

    assign bus.outstanding  = fifo_count;
    assign bus.orphan_error = orphan_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed scenarios followed by randomized traffic against a queue-based model
// of round-robin issue order and in-order response ownership.
module tb_spi_cmd_arbiter;

    localparam int NR = 2;
    localparam int DW = 16;
    localparam int MO = 8;

    typedef struct {
        int              idx;
        bit              disc;
        logic [DW-1:0]   data;
    } exp_t;

    logic sys_clk = 1'b0;
    logic reset;
    always #5 sys_clk = ~sys_clk;

    spi_cmd_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

    spi_cmd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state for the randomized phase
    exp_t          inflight[$];
    logic [DW-1:0] spi_q[$];
    logic [DW-1:0] mdl_data [NR];
    logic          mdl_user [NR];
    int            rr_m;
    int            pred_g;
    logic [NR-1:0] prev_valid;
    logic          prev_cmd;
    logic [NR-1:0] acc;
    bit            resp_used;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic u);
        bus.req_tvalid[i]          = v;
        bus.req_tdata[i*DW +: DW]  = d;
        bus.req_tuser[i]           = u;
    endtask

    // One randomized clock cycle: drive after the edge, check on the falling edge.
    task automatic rand_cycle(input bit allow_new);
        logic exp_rr;
        logic [NR-1:0] exp_rv;
        int g;
        tick();
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                bus.req_tvalid[i] = 1'b0;
            end
            if (!bus.req_tvalid[i] && allow_new && $urandom_range(0, 99) < 50) begin
                mdl_data[i] = DW'($urandom);
                mdl_user[i] = 1'($urandom_range(0, 1));
                set_req(i, 1'b1, mdl_data[i], mdl_user[i]);
            end
        end
        acc = '0;
        bus.rsp_tready = NR'($urandom);
        bus.cmd_tready = ($urandom_range(0, 99) < 60);
        if (resp_used) begin
            bus.resp_tvalid = 1'b0;
            resp_used = 1'b0;
        end
        if (!bus.resp_tvalid && spi_q.size() > 0 && $urandom_range(0, 99) < 50) begin
            bus.resp_tvalid = 1'b1;
            bus.resp_tdata  = spi_q[0] ^ 16'h5A5A;
        end
        sample();
        check_eq("rnd_outstanding", bus.outstanding, inflight.size());
        exp_rr = 1'b0;
        if (bus.resp_tvalid && inflight.size() > 0) begin
            exp_rv = inflight[0].disc ? '0 : (NR'(1) << inflight[0].idx);
            exp_rr = inflight[0].disc | bus.rsp_tready[inflight[0].idx];
            check_eq("rnd_rsp_tvalid", bus.rsp_tvalid, exp_rv);
            check_eq("rnd_resp_tready", bus.resp_tready, exp_rr);
            check_eq("rnd_rsp_tdata", bus.rsp_tdata, inflight[0].data ^ 16'h5A5A);
        end
        if (bus.cmd_tvalid && !prev_cmd) begin
            g = -1;
            for (int k = NR - 1; k >= 0; k--) begin
                if (prev_valid[(rr_m + k) % NR]) g = (rr_m + k) % NR;
            end
            check_eq("rnd_grant_had_valid", (g >= 0), 1);
            pred_g = (g < 0) ? 0 : g;
            check_eq("rnd_cmd_tdata", bus.cmd_tdata, mdl_data[pred_g]);
        end
        if (bus.cmd_tvalid && bus.cmd_tready) begin
            check_eq("rnd_req_tready", bus.req_tready, NR'(1) << pred_g);
            inflight.push_back('{idx: pred_g, disc: mdl_user[pred_g], data: mdl_data[pred_g]});
            spi_q.push_back(bus.cmd_tdata);
            rr_m = (pred_g + 1) % NR;
            acc[pred_g] = 1'b1;
        end else begin
            check_eq("rnd_req_tready_idle", bus.req_tready, 0);
        end
        if (bus.resp_tvalid && exp_rr) begin
            void'(inflight.pop_front());
            void'(spi_q.pop_front());
            resp_used = 1'b1;
        end
        prev_valid = bus.req_tvalid;
        prev_cmd   = bus.cmd_tvalid;
    endtask

    initial begin
        int hs;
        int hs2;
        int g;
        int cnt[NR];
        logic [NR-1:0] ev;

        reset = 1'b0;
        bus.req_tdata   = '0;
        bus.req_tuser   = '0;
        bus.req_tvalid  = '0;
        bus.rsp_tready  = '0;
        bus.cmd_tready  = 1'b0;
        bus.resp_tdata  = '0;
        bus.resp_tvalid = 1'b0;
        tick();
        tick();
        sample();
        check_eq("rst_cmd_tvalid", bus.cmd_tvalid, 0);
        check_eq("rst_cmd_tdata", bus.cmd_tdata, 0);
        check_eq("rst_req_tready", bus.req_tready, 0);
        check_eq("rst_rsp_tvalid", bus.rsp_tvalid, 0);
        check_eq("rst_resp_tready", bus.resp_tready, 0);
        check_eq("rst_outstanding", bus.outstanding, 0);
        check_eq("rst_orphan", bus.orphan_error, 0);
        reset = 1'b1;

        // Single write-only command
        tick();
        set_req(0, 1'b1, 16'h2D08, 1'b1);
        sample();
        check_eq("t1_cmd_not_yet", bus.cmd_tvalid, 0);
        tick();
        sample();
        check_eq("t1_cmd_tvalid", bus.cmd_tvalid, 1);
        check_eq("t1_cmd_tdata", bus.cmd_tdata, 16'h2D08);
        check_eq("t1_outstanding0", bus.outstanding, 0);
        tick();
        bus.cmd_tready = 1'b1;
        sample();
        check_eq("t1_req_tready", bus.req_tready, 2'b01);
        tick();
        bus.req_tvalid = '0;
        bus.cmd_tready = 1'b0;
        sample();
        check_eq("t1_cmd_dropped", bus.cmd_tvalid, 0);
        check_eq("t1_req_tready_off", bus.req_tready, 0);
        check_eq("t1_outstanding1", bus.outstanding, 1);
        tick();
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = 16'h00FF;
        sample();
        check_eq("t1_no_rsp_tvalid", bus.rsp_tvalid, 0);
        check_eq("t1_resp_tready", bus.resp_tready, 1);
        tick();
        bus.resp_tvalid = 1'b0;
        sample();
        check_eq("t1_outstanding_end", bus.outstanding, 0);
        $display("test single command: cmd 2d08 issued, response dropped");

        // Read routing with requester backpressure
        tick();
        set_req(1, 1'b1, 16'h8000, 1'b0);
        bus.cmd_tready = 1'b1;
        tick();
        sample();
        check_eq("t2_cmd_tdata", bus.cmd_tdata, 16'h8000);
        check_eq("t2_req_tready", bus.req_tready, 2'b10);
        tick();
        bus.req_tvalid  = '0;
        bus.cmd_tready  = 1'b0;
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = 16'h00E5;
        bus.rsp_tready  = '0;
        for (int c = 0; c < 5; c++) begin
            sample();
            check_eq("t2_rsp_tvalid", bus.rsp_tvalid, 2'b10);
            check_eq("t2_rsp_tdata", bus.rsp_tdata, 16'h00E5);
            check_eq("t2_resp_tready_hold", bus.resp_tready, 0);
            tick();
        end
        bus.rsp_tready = 2'b10;
        sample();
        check_eq("t2_resp_tready", bus.resp_tready, 1);
        tick();
        bus.resp_tvalid = 1'b0;
        bus.rsp_tready  = '0;
        sample();
        check_eq("t2_outstanding_end", bus.outstanding, 0);
        $display("test read routing: rsp 00e5 delivered to requester 1");

        // Round-robin fairness
        tick();
        cnt = '{0, 0};
        set_req(0, 1'b1, 16'hA000, 1'b0);
        set_req(1, 1'b1, 16'hB000, 1'b0);
        bus.cmd_tready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30 && hs < 4; c++) begin
            sample();
            g = -1;
            if (bus.req_tready != 0) begin
                g = bus.req_tready[1] ? 1 : 0;
                check_eq("t3_order", g, hs % 2);
                check_eq("t3_cmd_tdata", bus.cmd_tdata, (g == 1 ? 16'hB000 : 16'hA000) + 16'(cnt[g]));
                hs++;
            end
            tick();
            if (g >= 0) begin
                cnt[g]++;
                set_req(g, (hs < 4), (g == 1 ? 16'hB000 : 16'hA000) + 16'(cnt[g]), 1'b0);
                if (hs >= 4) bus.req_tvalid = '0;
            end
        end
        check_eq("t3_issued", hs, 4);
        bus.req_tvalid = '0;
        bus.cmd_tready = 1'b0;
        bus.rsp_tready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus.resp_tvalid = 1'b1;
            bus.resp_tdata  = 16'hC000 + 16'(k);
            sample();
            ev = (k % 2 == 0) ? 2'b01 : 2'b10;
            check_eq("t3_rsp_owner", bus.rsp_tvalid, ev);
            check_eq("t3_rsp_tdata", bus.rsp_tdata, 16'hC000 + 16'(k));
            tick();
        end
        bus.resp_tvalid = 1'b0;
        bus.rsp_tready  = '0;
        sample();
        check_eq("t3_outstanding_end", bus.outstanding, 0);
        $display("test round robin: order 0,1,0,1 with matching responses");

        // Full tag FIFO
        tick();
        set_req(0, 1'b1, 16'h3300, 1'b1);
        bus.cmd_tready = 1'b1;
        hs = 0;
        for (int c = 0; c < 30; c++) begin
            sample();
            if (bus.req_tready != 0) hs++;
            tick();
        end
        sample();
        check_eq("t4_issued", hs, 8);
        check_eq("t4_outstanding_full", bus.outstanding, 8);
        check_eq("t4_req_tready_full", bus.req_tready, 0);
        tick();
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = 16'h0000;
        sample();
        check_eq("t4_resp_tready", bus.resp_tready, 1);
        tick();
        bus.resp_tvalid = 1'b0;
        hs2 = 0;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (bus.req_tready != 0) hs2++;
            tick();
        end
        check_eq("t4_ninth", hs2, 1);
        bus.req_tvalid  = '0;
        bus.resp_tvalid = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        bus.resp_tvalid = 1'b0;
        sample();
        check_eq("t4_drained", bus.outstanding, 0);
        $display("test full: 8 issued, 9th after one response");

        // Orphan response
        tick();
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = 16'h1234;
        sample();
        check_eq("t5_resp_tready", bus.resp_tready, 1);
        check_eq("t5_no_rsp_tvalid", bus.rsp_tvalid, 0);
        check_eq("t5_orphan_before", bus.orphan_error, 0);
        tick();
        bus.resp_tvalid = 1'b0;
        sample();
        check_eq("t5_orphan_set", bus.orphan_error, 1);
        tick();
        tick();
        sample();
        check_eq("t5_orphan_sticky", bus.orphan_error, 1);
        $display("test orphan: 1234 dropped, orphan_error set");

        // Asynchronous reset while a command is being offered
        tick();
        set_req(0, 1'b1, 16'h4400, 1'b1);
        bus.cmd_tready = 1'b1;
        hs = 0;
        for (int c = 0; c < 20 && hs < 3; c++) begin
            sample();
            if (bus.req_tready != 0) hs++;
            tick();
        end
        bus.cmd_tready = 1'b0;
        check_eq("t6_issued", hs, 3);
        tick();
        sample();
        check_eq("t6_in_issue", bus.cmd_tvalid, 1);
        check_eq("t6_outstanding3", bus.outstanding, 3);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_cmd_tvalid", bus.cmd_tvalid, 0);
        check_eq("t6_cmd_tdata", bus.cmd_tdata, 0);
        check_eq("t6_outstanding", bus.outstanding, 0);
        check_eq("t6_orphan", bus.orphan_error, 0);
        check_eq("t6_resp_tready", bus.resp_tready, 0);
        check_eq("t6_req_tready", bus.req_tready, 0);
        set_req(0, 1'b1, 16'h5A00, 1'b0);
        sample();
        #2;
        reset = 1'b1;
        tick();
        sample();
        check_eq("t6_new_cmd", bus.cmd_tvalid, 1);
        check_eq("t6_new_tdata", bus.cmd_tdata, 16'h5A00);
        tick();
        bus.cmd_tready = 1'b1;
        tick();
        bus.req_tvalid  = '0;
        bus.cmd_tready  = 1'b0;
        bus.resp_tvalid = 1'b1;
        bus.resp_tdata  = 16'h1111;
        bus.rsp_tready  = 2'b01;
        sample();
        check_eq("t6_rsp_owner", bus.rsp_tvalid, 2'b01);
        tick();
        bus.resp_tvalid = 1'b0;
        bus.rsp_tready  = '0;
        sample();
        check_eq("t6_outstanding_end", bus.outstanding, 0);
        check_eq("t6_orphan_clear", bus.orphan_error, 0);
        $display("test async reset: cleared, new command 5a00 issued");

        // Randomized traffic
        rr_m       = 1;
        pred_g     = 0;
        acc        = '0;
        resp_used  = 1'b0;
        prev_valid = bus.req_tvalid;
        prev_cmd   = bus.cmd_tvalid;
        for (int i = 0; i < NR; i++) begin
            mdl_data[i] = '0;
            mdl_user[i] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            rand_cycle(1'b1);
        end
        for (int c = 0; c < 3000 && (inflight.size() > 0 || bus.req_tvalid != 0 || acc != 0); c++) begin
            rand_cycle(1'b0);
        end
        check_eq("rnd_drained", inflight.size(), 0);
        check_eq("rnd_orphan", bus.orphan_error, 0);
        $display("test random: traffic complete");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
